// File: rtl/x_count_alarm.sv
// Compare-match alarm fed by a 32-bit free-running counter; compare word loaded serially, LSB first.
// Define X_COUNT_ALARM_REARM_EN for periodic mode (cmp advances by the armed interval on each match).
module x_count_alarm (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_count_0,
  input  logic i_count_1,
  input  logic i_count_2,
  input  logic i_count_3,
  input  logic i_count_4,
  input  logic i_count_5,
  input  logic i_count_6,
  input  logic i_count_7,
  input  logic i_count_8,
  input  logic i_count_9,
  input  logic i_count_10,
  input  logic i_count_11,
  input  logic i_count_12,
  input  logic i_count_13,
  input  logic i_count_14,
  input  logic i_count_15,
  input  logic i_count_16,
  input  logic i_count_17,
  input  logic i_count_18,
  input  logic i_count_19,
  input  logic i_count_20,
  input  logic i_count_21,
  input  logic i_count_22,
  input  logic i_count_23,
  input  logic i_count_24,
  input  logic i_count_25,
  input  logic i_count_26,
  input  logic i_count_27,
  input  logic i_count_28,
  input  logic i_count_29,
  input  logic i_count_30,
  input  logic i_count_31,
  input  logic i_sen,
  input  logic i_sdi,
  input  logic i_arm,
  input  logic i_disarm,
  input  logic i_ack,
  output logic o_armed,
  output logic o_match,
  output logic o_fired
);

  typedef enum logic [1:0] {StIdle, StArmed, StFired} state_e;

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;
  logic        fired_q, fired_d;
  logic        armed_q;
  logic [31:0] count;
  logic        hit;
`ifdef X_COUNT_ALARM_REARM_EN
  logic [31:0] int_q, int_d;
`endif

  assign count = {i_count_31, i_count_30, i_count_29, i_count_28,
                  i_count_27, i_count_26, i_count_25, i_count_24,
                  i_count_23, i_count_22, i_count_21, i_count_20,
                  i_count_19, i_count_18, i_count_17, i_count_16,
                  i_count_15, i_count_14, i_count_13, i_count_12,
                  i_count_11, i_count_10, i_count_9,  i_count_8,
                  i_count_7,  i_count_6,  i_count_5,  i_count_4,
                  i_count_3,  i_count_2,  i_count_1,  i_count_0};

  assign hit = (state_q == StArmed) && (count == cmp_q);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cmp_d   = cmp_q;
    match_d = 1'b0;
    fired_d = fired_q;
`ifdef X_COUNT_ALARM_REARM_EN
    int_d   = int_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_sen) shift_d = {i_sdi, shift_q[31:1]};
        // Arm captures the pre-edge buffer, so a same-cycle shift is not armed.
        if (i_arm) begin
          cmp_d   = shift_q;
`ifdef X_COUNT_ALARM_REARM_EN
          int_d   = shift_q;
`endif
          state_d = StArmed;
        end
        if (i_ack) fired_d = 1'b0;
      end
      StArmed: begin
        if (hit) begin
          match_d = 1'b1;
          fired_d = 1'b1;
`ifdef X_COUNT_ALARM_REARM_EN
          cmp_d   = cmp_q + int_q;
`else
          state_d = StFired;
`endif
        end else if (i_disarm) begin
          state_d = StIdle;
        end else if (i_ack) begin
          fired_d = 1'b0;
        end
      end
      StFired: begin
        if (i_ack) begin
          state_d = StIdle;
          fired_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      fired_q <= 1'b0;
      armed_q <= 1'b0;
`ifdef X_COUNT_ALARM_REARM_EN
      int_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      fired_q <= fired_d;
      armed_q <= (state_d == StArmed);
`ifdef X_COUNT_ALARM_REARM_EN
      int_q   <= int_d;
`endif
    end
  end

  assign o_armed = armed_q;
  assign o_match = match_q;
  assign o_fired = fired_q;

endmodule

// File: tb/tb_x_count_alarm.sv
// Self-checking bench for x_count_alarm: vector table, directed sequences and random traffic
// against an event-level reference model.
module tb_x_count_alarm;

`ifdef X_COUNT_ALARM_REARM_EN
  localparam bit Rearm = 1'b1;
`else
  localparam bit Rearm = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0, sen = 1'b0, sdi = 1'b0, arm = 1'b0, disarm = 1'b0, ack = 1'b0;
  logic [31:0] count = '0;
  logic        armed, match, fired;

  always #5 clk = ~clk;

  x_count_alarm dut (
    .i_clk(clk), .i_rst(rst),
    .i_count_0(count[0]),   .i_count_1(count[1]),   .i_count_2(count[2]),
    .i_count_3(count[3]),   .i_count_4(count[4]),   .i_count_5(count[5]),
    .i_count_6(count[6]),   .i_count_7(count[7]),   .i_count_8(count[8]),
    .i_count_9(count[9]),   .i_count_10(count[10]), .i_count_11(count[11]),
    .i_count_12(count[12]), .i_count_13(count[13]), .i_count_14(count[14]),
    .i_count_15(count[15]), .i_count_16(count[16]), .i_count_17(count[17]),
    .i_count_18(count[18]), .i_count_19(count[19]), .i_count_20(count[20]),
    .i_count_21(count[21]), .i_count_22(count[22]), .i_count_23(count[23]),
    .i_count_24(count[24]), .i_count_25(count[25]), .i_count_26(count[26]),
    .i_count_27(count[27]), .i_count_28(count[28]), .i_count_29(count[29]),
    .i_count_30(count[30]), .i_count_31(count[31]),
    .i_sen(sen), .i_sdi(sdi), .i_arm(arm), .i_disarm(disarm), .i_ack(ack),
    .o_armed(armed), .o_match(match), .o_fired(fired)
  );

  // Reference model: "waiting" = armed and watching, "holding" = one-shot fired, awaiting ack.
  logic [31:0] m_buf, m_target, m_step;
  bit          m_waiting, m_holding, m_pulse, m_flag;
  int          n_cmp = 0, n_bad = 0, n_pulse = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [31:0] old_buf;
    old_buf = m_buf;
    m_pulse = 1'b0;
    if (rst) begin
      m_buf = 0; m_target = 0; m_step = 0;
      m_waiting = 0; m_holding = 0; m_flag = 0;
    end else if (m_waiting) begin
      if (count == m_target) begin
        m_pulse = 1'b1;
        m_flag  = 1'b1;
        if (Rearm) m_target = m_target + m_step;
        else begin m_waiting = 0; m_holding = 1; end
      end else if (disarm) m_waiting = 0;
      else if (ack) m_flag = 0;
    end else if (m_holding) begin
      if (ack) begin m_holding = 0; m_flag = 0; end
    end else begin
      if (sen) m_buf = (old_buf >> 1) | ({31'b0, sdi} << 31);
      if (arm) begin m_target = old_buf; m_step = old_buf; m_waiting = 1; end
      if (ack) m_flag = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("armed", {31'b0, armed}, {31'b0, m_waiting});
    check("match", {31'b0, match}, {31'b0, m_pulse});
    check("fired", {31'b0, fired}, {31'b0, m_flag});
    if (match === 1'b1) n_pulse++;
  endtask

  task automatic drive(input logic r, input logic a, input logic d, input logic k,
                       input logic [31:0] c);
    rst = r; arm = a; disarm = d; ack = k; count = c; sen = 1'b0; sdi = 1'b0;
    tick();
  endtask

  task automatic shift_word(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rst = 0; arm = 0; disarm = 0; ack = 0; sen = 1'b1; sdi = w[i];
      tick();
    end
    sen = 1'b0;
  endtask

  typedef struct {
    logic        rst, arm, disarm, ack;
    logic [31:0] count;
    logic        e_armed, e_match, e_fired;
  } vec_t;
  vec_t tbl[11];

  initial begin
    m_buf = 0; m_target = 0; m_step = 0;
    m_waiting = 0; m_holding = 0; m_pulse = 0; m_flag = 0;

    // Compare word stays 0 (no shifting), so count=0 is the match value.
    tbl[0]  = '{1, 0, 0, 0, 32'd0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 32'd5, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 32'd7, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 32'd0, Rearm, 1, 1};
    tbl[4]  = '{0, 0, 0, 0, 32'd0, Rearm, Rearm, 1};
    tbl[5]  = '{0, 0, 0, 1, 32'd3, Rearm, 0, 0};
    tbl[6]  = '{0, 0, 1, 0, 32'd9, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 32'd0, 1, 0, 0};
    tbl[8]  = '{0, 0, 1, 0, 32'd0, Rearm, 1, 1};
    tbl[9]  = '{0, 0, 0, 1, 32'd1, Rearm, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 32'd0, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rst, tbl[i].arm, tbl[i].disarm, tbl[i].ack, tbl[i].count);
      check($sformatf("tbl%0d_armed", i), {31'b0, armed}, {31'b0, tbl[i].e_armed});
      check($sformatf("tbl%0d_match", i), {31'b0, match}, {31'b0, tbl[i].e_match});
      check($sformatf("tbl%0d_fired", i), {31'b0, fired}, {31'b0, tbl[i].e_fired});
    end

    // Fire at 0x10, ack three cycles later, then a second pass must stay quiet.
    drive(1, 0, 0, 0, 0);
    shift_word(32'h10, 32);
    drive(0, 1, 0, 0, 0);
    n_pulse = 0;
    for (int c = 0; c <= 'h12; c++) begin
      drive(0, 0, 0, 0, c);
      if (c == 'h10) begin
        check("s1_match_at_10", {31'b0, match}, 32'd1);
        check("s1_armed_after_fire", {31'b0, armed}, {31'b0, Rearm});
      end
    end
    check("s1_pulses", n_pulse, 1);
    drive(0, 0, 0, 1, 32'h13);
    check("s2_fired_cleared", {31'b0, fired}, 32'd0);
    n_pulse = 0;
    for (int c = 0; c <= 'h14; c++) drive(0, 0, 0, 0, c);
    check("s2_second_pass", n_pulse, 0);

    // Disarm without match, then disarm coinciding with the match.
    drive(1, 0, 0, 0, 0);
    shift_word(32'h20, 32);
    drive(0, 1, 0, 0, 0);
    n_pulse = 0;
    for (int c = 1; c <= 5; c++) drive(0, 0, c == 5, 0, c);
    check("s3_disarmed", {31'b0, armed}, 32'd0);
    check("s3_no_pulse", n_pulse, 0);
    drive(0, 1, 0, 0, 32'h1d);
    for (int c = 'h1e; c <= 'h20; c++) drive(0, 0, c == 'h20, 0, c);
    check("s3_match_wins", {31'b0, match}, 32'd1);

    // Arm at the top of the range and wrap through zero.
    drive(1, 0, 0, 0, 0);
    shift_word(32'hFFFF_FFFF, 32);
    drive(0, 1, 0, 0, 32'hFFFF_FFF0);
    n_pulse = 0;
    begin
      logic [31:0] c;
      c = 32'hFFFF_FFF0;
      for (int i = 0; i < 20; i++) begin
        drive(0, 0, 0, 0, c);
        c = c + 1;
      end
    end
    check("s4_wrap_pulses", n_pulse, 1);

    // Reset mid-load must leave no residue.
    drive(1, 0, 0, 0, 0);
    shift_word(32'hFFFF_FFFF, 16);
    drive(1, 0, 0, 0, 0);
    shift_word(32'h3, 32);
    drive(0, 1, 0, 0, 0);
    n_pulse = 0;
    for (int c = 0; c <= 5; c++) begin
      drive(0, 0, 0, 0, c);
      if (c == 3) check("s5_match_at_3", {31'b0, match}, 32'd1);
    end
    check("s5_pulses", n_pulse, 1);

    if (Rearm) begin
      drive(1, 0, 0, 0, 0);
      shift_word(32'h8, 32);
      drive(0, 1, 0, 0, 32'd0);
      n_pulse = 0;
      for (int c = 0; c <= 26; c++) begin
        drive(0, 0, 0, c == 16, c);
        if (c == 16) begin
          check("s6_match_16", {31'b0, match}, 32'd1);
          check("s6_set_wins", {31'b0, fired}, 32'd1);
        end
      end
      check("s6_pulses", n_pulse, 3);
    end

    // Random traffic, count biased toward the model's target to get matches.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      sen    = $urandom_range(0, 1);
      sdi    = $urandom_range(0, 1);
      arm    = ($urandom_range(0, 7) == 0);
      disarm = ($urandom_range(0, 15) == 0);
      ack    = ($urandom_range(0, 7) == 0);
      count  = ($urandom_range(0, 3) == 0) ? m_target : $urandom();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
